uart_xcvr: RTL and testbench

Parametrised full-duplex UART transceiver, the successor to the current UART top. It integrates a runtime-programmable baud tick generator, an oversampling receiver and a transmitter with a valid/ready handshake. Frame format is selectable at run time: data width up to D_W, parity none/even/odd, and 1 or 2 stop bits. The receiver reports parity and framing errors alongside each received word. It sits between the pad-level rxd/txd pins and the on-chip consumer/producer logic.

---
 rtl/uart_xcvr.sv | 234 +++++++++++++++++++++++
 tb/tb_uart_xcvr.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_xcvr.sv
// Full-duplex UART: shared baud tick generator, oversampling RX, handshaked TX.
// Ports: clk/reset, dvsr (tick = dvsr+1 clks), parity_mode, stop2,
//   tx_data/tx_valid/tx_ready -> txd, rxd -> rx_data/rx_valid/rx_*_err.
module uart_xcvr #(
  parameter int D_W    = 8,
  parameter int B_TICK = 16,
  parameter int DVSR_W = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DVSR_W-1:0] dvsr,
  input  logic [1:0]        parity_mode,
  input  logic              stop2,
  input  logic [D_W-1:0]    tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              txd,
  input  logic              rxd,
  output logic [D_W-1:0]    rx_data,
  output logic              rx_valid,
  output logic              rx_parity_err,
  output logic              rx_frame_err
);

  localparam int SW = $clog2(2 * B_TICK);
  localparam int NW = $clog2(D_W + 1);

  localparam logic [SW-1:0] HALF_M1 = SW'(B_TICK / 2 - 1);
  localparam logic [SW-1:0] BIT_M1  = SW'(B_TICK - 1);
  localparam logic [SW-1:0] STP2_M1 = SW'(2 * B_TICK - 1);
  localparam logic [NW-1:0] LAST    = NW'(D_W - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_t;

  // Tick generator; a shrinking dvsr below the count wraps at 2^DVSR_W.
  logic [DVSR_W-1:0] tcnt;
  logic              tick;

  assign tick = (tcnt == dvsr);

  always_ff @(posedge clk) begin
    if (reset)     tcnt <= '0;
    else if (tick) tcnt <= '0;
    else           tcnt <= tcnt + 1'b1;
  end

  // Receiver
  logic           rx_s1, rx_s2;
  state_t         rx_st;
  logic [SW-1:0]  rx_tc;
  logic [NW-1:0]  rx_n;
  logic [D_W-1:0] rx_sh;
  logic           rx_pen, rx_podd, rx_perr;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s1         <= 1'b1;
      rx_s2         <= 1'b1;
      rx_st         <= IDLE;
      rx_tc         <= '0;
      rx_n          <= '0;
      rx_sh         <= '0;
      rx_pen        <= 1'b0;
      rx_podd       <= 1'b0;
      rx_perr       <= 1'b0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
    end else begin
      rx_s1    <= rxd;
      rx_s2    <= rx_s1;
      rx_valid <= 1'b0;
      case (rx_st)
        IDLE: begin
          if (!rx_s2) begin
            rx_st   <= START;
            rx_tc   <= '0;
            rx_pen  <= ^parity_mode;
            rx_podd <= (parity_mode == 2'b10);
            rx_perr <= 1'b0;
          end
        end
        START: begin
          if (tick) begin
            if (rx_tc == HALF_M1) begin
              // Line back high at mid-start: a glitch.
              if (!rx_s2) begin
                rx_tc <= '0;
                rx_n  <= '0;
                rx_st <= DATA;
              end else begin
                rx_st <= IDLE;
              end
            end else begin
              rx_tc <= rx_tc + 1'b1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (rx_tc == BIT_M1) begin
              rx_tc <= '0;
              rx_sh <= {rx_s2, rx_sh[D_W-1:1]};
              if (rx_n == LAST)
                rx_st <= rx_pen ? PARITY : STOP;
              else
                rx_n <= rx_n + 1'b1;
            end else begin
              rx_tc <= rx_tc + 1'b1;
            end
          end
        end
        PARITY: begin
          if (tick) begin
            if (rx_tc == BIT_M1) begin
              rx_tc   <= '0;
              rx_perr <= rx_s2 ^ (^rx_sh) ^ rx_podd;
              rx_st   <= STOP;
            end else begin
              rx_tc <= rx_tc + 1'b1;
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (rx_tc == BIT_M1) begin
              rx_tc         <= '0;
              rx_data       <= rx_sh;
              rx_parity_err <= rx_perr;
              rx_frame_err  <= !rx_s2;
              rx_valid      <= 1'b1;
              rx_st         <= IDLE;
            end else begin
              rx_tc <= rx_tc + 1'b1;
            end
          end
        end
        default: rx_st <= IDLE;
      endcase
    end
  end

  // Transmitter
  state_t         tx_st;
  logic [SW-1:0]  tx_tc;
  logic [NW-1:0]  tx_n;
  logic [D_W-1:0] tx_sh;
  logic           tx_pen, tx_pbit, tx_s2;

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_st    <= IDLE;
      tx_tc    <= '0;
      tx_n     <= '0;
      tx_sh    <= '0;
      tx_pen   <= 1'b0;
      tx_pbit  <= 1'b0;
      tx_s2    <= 1'b0;
      tx_ready <= 1'b1;
      txd      <= 1'b1;
    end else begin
      case (tx_st)
        IDLE: begin
          if (tx_valid) begin
            tx_sh    <= tx_data;
            tx_pen   <= ^parity_mode;
            tx_pbit  <= (^tx_data) ^ (parity_mode == 2'b10);
            tx_s2    <= stop2;
            tx_tc    <= '0;
            tx_ready <= 1'b0;
            txd      <= 1'b0;
            tx_st    <= START;
          end
        end
        START: begin
          if (tick) begin
            if (tx_tc == BIT_M1) begin
              tx_tc <= '0;
              tx_n  <= '0;
              txd   <= tx_sh[0];
              tx_st <= DATA;
            end else begin
              tx_tc <= tx_tc + 1'b1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (tx_tc == BIT_M1) begin
              tx_tc <= '0;
              tx_sh <= tx_sh >> 1;
              if (tx_n == LAST) begin
                txd   <= tx_pen ? tx_pbit : 1'b1;
                tx_st <= tx_pen ? PARITY : STOP;
              end else begin
                tx_n <= tx_n + 1'b1;
                txd  <= tx_sh[1];
              end
            end else begin
              tx_tc <= tx_tc + 1'b1;
            end
          end
        end
        PARITY: begin
          if (tick) begin
            if (tx_tc == BIT_M1) begin
              tx_tc <= '0;
              txd   <= 1'b1;
              tx_st <= STOP;
            end else begin
              tx_tc <= tx_tc + 1'b1;
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (tx_tc == (tx_s2 ? STP2_M1 : BIT_M1)) begin
              tx_tc    <= '0;
              tx_ready <= 1'b1;
              tx_st    <= IDLE;
            end else begin
              tx_tc <= tx_tc + 1'b1;
            end
          end
        end
        default: tx_st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_xcvr.sv
// Bench for uart_xcvr: table-driven TX frames in loopback with an RX
// scoreboard, plus hand sequences for reset, RX errors and glitches.
module tb_uart_xcvr;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] dvsr;
  logic [1:0]  parity_mode;
  logic        stop2;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        txd;
  logic        rxd;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_parity_err;
  logic        rx_frame_err;
  logic        loop;
  logic        rxd_drv;

  always #5 clk = ~clk;

  assign rxd = loop ? txd : rxd_drv;

  uart_xcvr #(.D_W(8), .B_TICK(16), .DVSR_W(11)) dut (
    .clk(clk),
    .reset(reset),
    .dvsr(dvsr),
    .parity_mode(parity_mode),
    .stop2(stop2),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .txd(txd),
    .rxd(rxd),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_parity_err(rx_parity_err),
    .rx_frame_err(rx_frame_err)
  );

  typedef struct {
    int         dv;
    logic [1:0] pm;
    logic       s2;
    logic [7:0] d;
    logic [1:0] pm_mid;
    int         n_bits;
    logic       pbit;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } rx_exp_t;

  rx_exp_t sb[$];
  rx_exp_t mon_e;
  int n_chk = 0;
  int n_err = 0;
  int rxv_cnt = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_rng(input string nm, input int act,
                         input int lo, input int hi);
    n_chk++;
    if (act < lo || act > hi) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  always @(negedge clk) begin
    if (rx_valid) begin
      rxv_cnt++;
      if (sb.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL rx_unexpected: got data %0h expected no frame",
                 rx_data);
      end else begin
        mon_e = sb.pop_front();
        chk("rx_data", int'(rx_data), int'(mon_e.d));
        chk("rx_parity_err", int'(rx_parity_err), int'(mon_e.pe));
        chk("rx_frame_err", int'(rx_frame_err), int'(mon_e.fe));
      end
    end
  end

  task automatic tx_frame(input vec_t v);
    int p, c;
    logic [15:0] bits;
    bit done;
    if (v.dv != int'(dvsr)) begin
      dvsr = 11'(v.dv);
      repeat (2100) @(negedge clk);
    end
    parity_mode = v.pm;
    stop2 = v.s2;
    p = 16 * (v.dv + 1);
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = v.d[i];
    if (v.pm == 2'b01 || v.pm == 2'b10) bits[9] = v.pbit;
    c = 0;
    while (!tx_ready && c < 5000) begin
      @(negedge clk);
      c++;
    end
    chk("tx_ready_wait", int'(tx_ready), 1);
    tx_data = v.d;
    tx_valid = 1'b1;
    if (loop) sb.push_back('{v.d, 1'b0, 1'b0});
    @(posedge clk);
    c = 0;
    done = 0;
    while (!done && c < v.n_bits * p + 50) begin
      @(negedge clk);
      c++;
      if (c == 1) tx_valid = 1'b0;
      if (c == 2 * p) begin
        tx_valid = 1'b1;
        tx_data = ~v.d;
      end
      if (c == 2 * p + 5) begin
        tx_valid = 1'b0;
        tx_data = v.d;
      end
      if (c == 3 * p) parity_mode = v.pm_mid;
      if (tx_ready) done = 1;
      else if (c % p == p / 2 && c / p < v.n_bits)
        chk($sformatf("txd_bit%0d_d%02h", c / p, v.d),
            int'(txd), int'(bits[c/p]));
    end
    chk_rng($sformatf("tx_busy_len_d%02h", v.d), c - 1,
            v.n_bits * p - v.dv, v.n_bits * p);
    tx_valid = 1'b0;
  endtask

  task automatic rx_send(input logic [7:0] d, input logic pbit,
                         input logic stp, input int stp_len,
                         input int p);
    rxd_drv = 1'b0;
    repeat (p) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd_drv = d[i];
      repeat (p) @(negedge clk);
    end
    rxd_drv = pbit;
    repeat (p) @(negedge clk);
    rxd_drv = stp;
    repeat (stp_len) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (3 * p) @(negedge clk);
  endtask

  vec_t tbl[10];

  initial begin
    int p, base, tr;
    logic prev;
    tbl[0] = '{3, 2'b00, 1'b0, 8'hA5, 2'b00, 10, 1'b0};
    tbl[1] = '{3, 2'b01, 1'b1, 8'h07, 2'b01, 12, 1'b1};
    tbl[2] = '{3, 2'b10, 1'b1, 8'h07, 2'b10, 12, 1'b0};
    tbl[3] = '{3, 2'b10, 1'b0, 8'h00, 2'b10, 11, 1'b1};
    tbl[4] = '{3, 2'b10, 1'b0, 8'hFF, 2'b10, 11, 1'b1};
    tbl[5] = '{3, 2'b10, 1'b0, 8'h3C, 2'b10, 11, 1'b1};
    tbl[6] = '{3, 2'b01, 1'b0, 8'h5A, 2'b00, 11, 1'b0};
    tbl[7] = '{3, 2'b00, 1'b0, 8'h5A, 2'b00, 10, 1'b0};
    tbl[8] = '{0, 2'b00, 1'b0, 8'hC3, 2'b00, 10, 1'b0};
    tbl[9] = '{1, 2'b10, 1'b1, 8'h81, 2'b10, 12, 1'b1};

    reset = 1'b1;
    dvsr = 11'd3;
    parity_mode = 2'b00;
    stop2 = 1'b0;
    tx_data = 8'h00;
    tx_valid = 1'b0;
    loop = 1'b1;
    rxd_drv = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_txd", int'(txd), 1);
    chk("rst_tx_ready", int'(tx_ready), 1);
    chk("rst_rx_valid", int'(rx_valid), 0);
    chk("rst_rx_data", int'(rx_data), 0);
    chk("rst_perr", int'(rx_parity_err), 0);
    chk("rst_ferr", int'(rx_frame_err), 0);

    for (int i = 0; i < 10; i++) tx_frame(tbl[i]);
    repeat (10) @(negedge clk);
    chk("sb_drained", sb.size(), 0);

    // Reset in the middle of a TX frame.
    tx_data = 8'h33;
    tx_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (100) @(negedge clk);
    chk("mid_txd_low", int'(txd), 0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("mrst_txd", int'(txd), 1);
    chk("mrst_tx_ready", int'(tx_ready), 1);
    chk("mrst_rx_valid", int'(rx_valid), 0);
    chk("mrst_rx_data", int'(rx_data), 0);
    base = rxv_cnt;
    tr = 0;
    prev = txd;
    repeat (300) begin
      @(negedge clk);
      if (txd != prev) tr++;
      prev = txd;
    end
    chk("mrst_txd_quiet", tr, 0);
    chk("mrst_no_rx", rxv_cnt - base, 0);

    // Directly driven RX frames with errors (even parity, dvsr=1).
    rxd_drv = 1'b1;
    loop = 1'b0;
    parity_mode = 2'b01;
    p = 16 * (int'(dvsr) + 1);
    repeat (p) @(negedge clk);
    base = rxv_cnt;
    sb.push_back('{8'h55, 1'b1, 1'b0});
    rx_send(8'h55, 1'b1, 1'b1, p, p);
    chk("rx_perr_pulses", rxv_cnt - base, 1);
    base = rxv_cnt;
    sb.push_back('{8'h55, 1'b0, 1'b1});
    rx_send(8'h55, 1'b0, 1'b0, 3 * p / 4, p);
    chk("rx_ferr_pulses", rxv_cnt - base, 1);

    // Short low glitch on an idle line.
    base = rxv_cnt;
    rxd_drv = 1'b0;
    repeat (3 * (int'(dvsr) + 1)) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (3 * p) @(negedge clk);
    chk("glitch_no_rx", rxv_cnt - base, 0);
    chk("sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
